k423_ex_div: RTL and testbench

Iterative radix-2 integer divider in the EX stage, executing RV32M DIV/DIVU/REM/REMU. It consumes operands from the ID/EX pipeline register. It reports busy to the PCU so ID/EX is stalled while a division is in flight. It returns a result with rd index to the EX writeback mux under a valid/ready handshake.

---
 rtl/k423_ex_div_pkg.sv | 28 ++
 rtl/k423_div_iter.sv | 22 ++
 rtl/k423_ex_div.sv | 162 ++++++++++++++++
 tb/tb_k423_ex_div.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/k423_ex_div_pkg.sv
// Shared constants, op encodings and FSM state type for the EX-stage divider.
package k423_ex_div_pkg;

   localparam int CORE_XLEN     = 32;
   localparam int INST_RSDIDX_W = 5;
   localparam int DIV_OP_W      = 2;
   localparam int DIV_CNT_W     = 6;

   localparam logic [DIV_OP_W-1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [DIV_OP_W-1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [DIV_OP_W-1:0] DIV_OP_REM  = 2'b10;
   localparam logic [DIV_OP_W-1:0] DIV_OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      DIV_ST_IDLE = 2'd0,
      DIV_ST_CALC = 2'd1,
      DIV_ST_DONE = 2'd2
   } div_state_e;

   function automatic logic div_op_signed(input logic [DIV_OP_W-1:0] op);
      return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
   endfunction

   function automatic logic div_op_rem(input logic [DIV_OP_W-1:0] op);
      return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
   endfunction

endpackage

// File: rtl/k423_div_iter.sv
// One combinational restoring-division step on unsigned magnitudes.
module k423_div_iter #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] dvs_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] rem_sh;
   logic [XLEN:0] trial;

   // The shifted remainder needs one extra bit: it can reach 2*divisor-1.
   assign rem_sh = {rem_i, quo_i[XLEN-1]};
   assign trial  = rem_sh - {1'b0, dvs_i};

   assign rem_o = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
   assign quo_o = {quo_i[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/k423_ex_div.sv
// Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU) in the EX stage.
// Optional macro DIV_FAST_ZERO_EN: divide-by-zero and signed overflow finish at accept.
module k423_ex_div
   import k423_ex_div_pkg::*;
#(
   parameter int XLEN = CORE_XLEN
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     pcu_clear_ex_i,
   input  logic                     div_vld_i,
   output logic                     div_rdy_o,
   input  logic [DIV_OP_W-1:0]      div_op_i,
   input  logic [XLEN-1:0]          div_rs1_i,
   input  logic [XLEN-1:0]          div_rs2_i,
   input  logic [INST_RSDIDX_W-1:0] div_rd_idx_i,
   output logic                     div_busy_o,
   output logic                     res_vld_o,
   input  logic                     res_rdy_i,
   output logic [XLEN-1:0]          res_o,
   output logic [INST_RSDIDX_W-1:0] res_rd_idx_o,
   output div_state_e               dbg_state_o
);

   // Handshakes: an operation transfers on a rising edge where div_vld_i & div_rdy_o
   // & !pcu_clear_ex_i; a result transfers where res_vld_o & res_rdy_i. Once raised,
   // res_vld_o and res_o hold until the transfer (or a clear/reset drops them).

   localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(XLEN - 1);

   div_state_e                 state_q, state_d;
   logic [DIV_OP_W-1:0]        op_q, op_d;
   logic [INST_RSDIDX_W-1:0]   rd_q, rd_d;
   logic [XLEN-1:0]            rem_q, rem_d;
   logic [XLEN-1:0]            quo_q, quo_d;
   logic [XLEN-1:0]            dvs_q, dvs_d;
   logic [DIV_CNT_W-1:0]       cnt_q, cnt_d;
   logic                       q_neg_q, q_neg_d;
   logic                       r_neg_q, r_neg_d;
   logic [XLEN-1:0]            res_q, res_d;

   logic [XLEN-1:0] rem_nxt, quo_nxt;
   logic [XLEN-1:0] q_fin, r_fin;
   logic            accept;
   logic            in_sgn, s1, s2, dvs_zero;

   k423_div_iter #(.XLEN(XLEN)) u_iter (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .dvs_i (dvs_q),
      .rem_o (rem_nxt),
      .quo_o (quo_nxt)
   );

   assign div_rdy_o = (state_q == DIV_ST_IDLE) || ((state_q == DIV_ST_DONE) && res_rdy_i);
   assign accept    = div_vld_i && div_rdy_o && !pcu_clear_ex_i;

   assign in_sgn   = div_op_signed(div_op_i);
   assign dvs_zero = (div_rs2_i == '0);
   assign s1       = in_sgn && div_rs1_i[XLEN-1];
   assign s2       = in_sgn && div_rs2_i[XLEN-1];

   assign q_fin = q_neg_q ? (~quo_nxt + 1'b1) : quo_nxt;
   assign r_fin = r_neg_q ? (~rem_nxt + 1'b1) : rem_nxt;

`ifdef DIV_FAST_ZERO_EN
   logic            fast_hit;
   logic [XLEN-1:0] fast_res;
   logic [XLEN-1:0] xlen_min;

   assign xlen_min = {1'b1, {(XLEN-1){1'b0}}};
   assign fast_hit = dvs_zero || (in_sgn && (div_rs1_i == xlen_min) && (div_rs2_i == '1));
   always_comb begin
      fast_res = '0;
      if (dvs_zero) fast_res = div_op_rem(div_op_i) ? div_rs1_i : '1;
      else          fast_res = div_op_rem(div_op_i) ? '0 : xlen_min;
   end
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rd_d    = rd_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      res_d   = res_q;

      case (state_q)
         DIV_ST_CALC: begin
            rem_d = rem_nxt;
            quo_d = quo_nxt;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               res_d   = div_op_rem(op_q) ? r_fin : q_fin;
               state_d = DIV_ST_DONE;
            end
         end
         DIV_ST_DONE: begin
            if (res_rdy_i) state_d = DIV_ST_IDLE;
         end
         default: ;
      endcase

      if (accept) begin
         op_d  = div_op_i;
         rd_d  = div_rd_idx_i;
         rem_d = '0;
         // With a zero divisor the raw rs1 is divided so the remainder comes out as rs1.
         quo_d   = (s1 && !dvs_zero) ? (~div_rs1_i + 1'b1) : div_rs1_i;
         dvs_d   = s2 ? (~div_rs2_i + 1'b1) : div_rs2_i;
         q_neg_d = !dvs_zero && (s1 ^ s2);
         r_neg_d = !dvs_zero && s1;
         cnt_d   = '0;
         state_d = DIV_ST_CALC;
`ifdef DIV_FAST_ZERO_EN
         if (fast_hit) begin
            res_d   = fast_res;
            state_d = DIV_ST_DONE;
         end
`endif
      end

      if (pcu_clear_ex_i) state_d = DIV_ST_IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= DIV_ST_IDLE;
         op_q    <= '0;
         rd_q    <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         res_q   <= res_d;
      end
   end

   assign div_busy_o   = (state_q != DIV_ST_IDLE);
   assign res_vld_o    = (state_q == DIV_ST_DONE);
   assign res_o        = res_q;
   assign res_rd_idx_o = res_vld_o ? rd_q : '0;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_k423_ex_div.sv
// Scoreboard bench for k423_ex_div: random and directed divides against an arithmetic model.
module tb_k423_ex_div;
   import k423_ex_div_pkg::*;

   localparam int XLEN = 32;
   localparam int RW   = INST_RSDIDX_W;
   localparam int EW   = RW + XLEN;
   localparam logic [XLEN-1:0] XMIN = 32'h8000_0000;

   logic            clk_i = 1'b0;
   logic            rst_n_i = 1'b0;
   logic            pcu_clear_ex_i = 1'b0;
   logic            div_vld_i = 1'b0;
   logic            div_rdy_o;
   logic [1:0]      div_op_i = '0;
   logic [XLEN-1:0] div_rs1_i = '0;
   logic [XLEN-1:0] div_rs2_i = '0;
   logic [RW-1:0]   div_rd_idx_i = '0;
   logic            div_busy_o;
   logic            res_vld_o;
   logic            res_rdy_i = 1'b1;
   logic [XLEN-1:0] res_o;
   logic [RW-1:0]   res_rd_idx_o;
   div_state_e      dbg_state;

   k423_ex_div #(.XLEN(XLEN)) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .pcu_clear_ex_i (pcu_clear_ex_i),
      .div_vld_i      (div_vld_i),
      .div_rdy_o      (div_rdy_o),
      .div_op_i       (div_op_i),
      .div_rs1_i      (div_rs1_i),
      .div_rs2_i      (div_rs2_i),
      .div_rd_idx_i   (div_rd_idx_i),
      .div_busy_o     (div_busy_o),
      .res_vld_o      (res_vld_o),
      .res_rdy_i      (res_rdy_i),
      .res_o          (res_o),
      .res_rd_idx_o   (res_rd_idx_o),
      .dbg_state_o    (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   logic rdy_rand_en = 1'b0;
   logic rdy_hold    = 1'b1;
   initial forever begin
      @(posedge clk_i);
      #2;
      res_rdy_i = rdy_rand_en ? ($urandom_range(0, 3) != 0) : rdy_hold;
   end

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int            acc_q[$];
   int            lat_q[$];
   int            n_checks = 0;
   int            n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: RISC-V M-extension division rules with plain integer arithmetic.
   function automatic logic [XLEN-1:0] ref_div(input logic [1:0] op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
      logic [XLEN-1:0] q, r;
      int sa, sb;
      if (b == 0) begin
         q = '1;
         r = a;
      end else if (op[0] == 1'b0) begin
         if (a == XMIN && b == '1) begin
            q = XMIN;
            r = '0;
         end else begin
            sa = int'(a);
            sb = int'(b);
            q  = XLEN'(sa / sb);
            r  = XLEN'(sa % sb);
         end
      end else begin
         q = a / b;
         r = a % b;
      end
      return op[1] ? r : q;
   endfunction

   function automatic int exp_lat(input logic [1:0] op, input logic [XLEN-1:0] a,
                                  input logic [XLEN-1:0] b);
`ifdef DIV_FAST_ZERO_EN
      if (b == 0 || (op[0] == 1'b0 && a == XMIN && b == '1)) return 1;
`endif
      return XLEN + 1;
   endfunction

   function automatic logic [XLEN-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 32'd1;
         2:       return '1;
         3:       return XMIN;
         4:       return XLEN'($urandom_range(0, 20));
         5:       return -XLEN'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- monitor ----------------
   logic          new_res = 1'b1;
   logic [EW-1:0] held;
   int            first_cyc = 0;

   initial forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
         new_res = 1'b1;
      end else if (res_vld_o) begin
         if (new_res) first_cyc = cyc;
         else check("hold_stable", 64'({res_rd_idx_o, res_o}), 64'(held));
         held = {res_rd_idx_o, res_o};
         if (res_rdy_i) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 64'(res_o), 64'hdead);
            end else begin
               check("result", 64'({res_rd_idx_o, res_o}), 64'(exp_q.pop_front()));
               check("latency", 64'(first_cyc - acc_q.pop_front() + 1), 64'(lat_q.pop_front()));
            end
            new_res = 1'b1;
         end else begin
            new_res = 1'b0;
         end
      end else begin
         new_res = 1'b1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Called just after a rising edge; returns just after the accept edge.
   task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [RW-1:0] rd);
      logic done;
      done = 1'b0;
      div_vld_i    = 1'b1;
      div_op_i     = op;
      div_rs1_i    = a;
      div_rs2_i    = b;
      div_rd_idx_i = rd;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk_i);
         if (div_rdy_o && !pcu_clear_ex_i) begin
            exp_q.push_back({rd, ref_div(op, a, b)});
            acc_q.push_back(cyc + 1);
            lat_q.push_back(exp_lat(op, a, b));
            done = 1'b1;
         end
         step();
      end
      div_vld_i = 1'b0;
      if (!done) check("issue_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk_i);
      if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
      step();
   endtask

   task automatic flush_sb();
      exp_q.delete();
      acc_q.delete();
      lat_q.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int vld_seen;
      int waited;

      @(negedge clk_i);
      check("rst_rdy", 64'(div_rdy_o), 64'd1);
      check("rst_vld", 64'(res_vld_o), 64'd0);
      check("rst_busy", 64'(div_busy_o), 64'd0);
      check("rst_res", 64'({res_rd_idx_o, res_o}), 64'd0);
      step();
      rst_n_i = 1'b1;
      step();

      // Directed arithmetic cases
      issue(DIV_OP_DIVU, 32'd100, 32'd7, 5'd1);
      issue(DIV_OP_REMU, 32'd100, 32'd7, 5'd2);
      issue(DIV_OP_DIV, -32'sd7, 32'd2, 5'd3);
      issue(DIV_OP_REM, -32'sd7, 32'd2, 5'd4);
      issue(DIV_OP_DIV, 32'd5, 32'd0, 5'd5);
      issue(DIV_OP_REM, 32'd5, 32'd0, 5'd6);
      issue(DIV_OP_REM, -32'sd5, 32'd0, 5'd7);
      issue(DIV_OP_DIVU, 32'd5, 32'd0, 5'd8);
      issue(DIV_OP_DIV, XMIN, 32'hFFFF_FFFF, 5'd9);
      issue(DIV_OP_REM, XMIN, 32'hFFFF_FFFF, 5'd10);
      issue(DIV_OP_DIVU, XMIN, 32'hFFFF_FFFF, 5'd11);
      drain();

      // Clear in the tenth CALC cycle
      issue(DIV_OP_DIVU, 32'd1000, 32'd3, 5'd12);
      repeat (9) step();
      pcu_clear_ex_i = 1'b1;
      flush_sb();
      step();
      pcu_clear_ex_i = 1'b0;
      @(negedge clk_i);
      check("clear_busy", 64'(div_busy_o), 64'd0);
      vld_seen = 0;
      repeat (40) begin
         @(negedge clk_i);
         if (res_vld_o) vld_seen++;
      end
      check("clear_no_result", 64'(vld_seen), 64'd0);
      step();
      issue(DIV_OP_DIVU, 32'd9, 32'd3, 5'd13);
      drain();

      // Op presented together with a clear is dropped
      div_vld_i      = 1'b1;
      div_op_i       = DIV_OP_DIVU;
      div_rs1_i      = 32'd50;
      div_rs2_i      = 32'd5;
      pcu_clear_ex_i = 1'b1;
      step();
      div_vld_i      = 1'b0;
      pcu_clear_ex_i = 1'b0;
      @(negedge clk_i);
      check("clear_blocks_accept", 64'(div_busy_o), 64'd0);
      step();

      // Back-pressure, then issue in the same cycle res_rdy_i rises
      rdy_hold = 1'b0;
      step();
      issue(DIV_OP_DIVU, 32'd1000, 32'd10, 5'd14);
      waited = 0;
      while (!res_vld_o && waited < 100) begin
         @(negedge clk_i);
         waited++;
      end
      check("bp_result_seen", 64'(res_vld_o), 64'd1);
      repeat (5) @(negedge clk_i);
      step();
      rdy_hold = 1'b1;
      issue(DIV_OP_REMU, 32'd1000, 32'd7, 5'd15);
      drain();

      // Asynchronous reset in the middle of a calculation
      issue(DIV_OP_DIV, 32'd77, 32'd7, 5'd16);
      repeat (4) step();
      rst_n_i = 1'b0;
      flush_sb();
      #1;
      check("async_rst_busy", 64'(div_busy_o), 64'd0);
      step();
      rst_n_i = 1'b1;
      step();

      // Randomized traffic with random back-pressure
      rdy_rand_en = 1'b1;
      for (int n = 0; n < 60; n++) begin
         repeat ($urandom_range(0, 3)) step();
         issue(2'($urandom_range(0, 3)), pick(), pick(), RW'($urandom));
      end
      drain();
      rdy_rand_en = 1'b0;
      step();
      check("end_idle", 64'(dbg_state), 64'(DIV_ST_IDLE));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
